// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and baud helper
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Rounded division keeps the bit period within half a clock of ideal
   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   localparam int DEFAULT_CLKS_PER_BIT = calc_clks_per_bit(100_000_000, 115_200);

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte request / serial line bundle of the UART transmitter
interface uart_tx_if;
   logic [7:0] data;
   logic       send;
   logic       tx;
   logic       busy_flag;
   logic       complate_flag;
   logic       error_flag;

   modport master (
      output data, send,
      input  tx, busy_flag, complate_flag, error_flag
   );

   modport slave (
      input  data, send,
      output tx, busy_flag, complate_flag, error_flag
   );
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a bit-end tick
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == LAST);

   // Count 0..CLKS_PER_BIT-1 while a frame runs; restart from zero on frame accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with optional even parity and 1/2 stop bits
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic     sysclk,
   input  logic     rst,
   uart_tx_if.slave bus
);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t state, state_n;
   logic [7:0]  shreg, shreg_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic        stop_idx, stop_idx_n;
   logic        parity, parity_n;
   logic        tx_q, tx_n;
   logic        busy_q, busy_n;
   logic        cmp_q, cmp_n;
   logic        err_q, err_n;
   logic        baud_clear;
   logic        bit_end;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (sysclk),
      .rst    (rst),
      .clear  (baud_clear),
      .enable (state != ST_IDLE),
      .tick   (bit_end)
   );

   assign bus.tx            = tx_q;
   assign bus.busy_flag     = busy_q;
   assign bus.complate_flag = cmp_q;
   assign bus.error_flag    = err_q;

   // State and all outputs are registered so TX moves on the same edge as the state
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         parity   <= 1'b0;
         tx_q     <= LINE_IDLE;
         busy_q   <= 1'b0;
         cmp_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         parity   <= parity_n;
         tx_q     <= tx_n;
         busy_q   <= busy_n;
         cmp_q    <= cmp_n;
         err_q    <= err_n;
      end
   end

   // Next-state logic; each case computes the line level for the bit that starts next
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      parity_n   = parity;
      tx_n       = tx_q;
      busy_n     = busy_q;
      cmp_n      = 1'b0;
      err_n      = bus.send && busy_q;
      baud_clear = 1'b0;

      case (state)
         ST_IDLE: begin
            // busy_q is already low on the completion cycle, so a chained request lands here
            if (bus.send && !busy_q) begin
               shreg_n    = bus.data;
               parity_n   = ^bus.data;
               bit_idx_n  = '0;
               baud_clear = 1'b1;
               tx_n       = START_LEVEL;
               busy_n     = 1'b1;
               state_n    = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_n    = shreg[0];
               state_n = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     tx_n    = parity;
                     state_n = ST_PARITY;
                  end else begin
                     tx_n       = STOP_LEVEL;
                     stop_idx_n = 1'b0;
                     state_n    = ST_STOP;
                  end
               end else begin
                  // Registered TX needs the bit that becomes bit 0 after this shift
                  shreg_n   = shreg >> 1;
                  tx_n      = shreg[1];
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               tx_n       = STOP_LEVEL;
               stop_idx_n = 1'b0;
               state_n    = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop_idx == LAST_STOP) begin
                  tx_n    = LINE_IDLE;
                  busy_n  = 1'b0;
                  cmp_n   = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  stop_idx_n = 1'b1;
               end
            end
         end
         default: begin
            tx_n    = LINE_IDLE;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across three frame formats
module tb_uart_tx;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_if ifa ();
   uart_tx_if ifb ();
   uart_tx_if ifc ();

   logic [7:0] data_v [3];
   logic       send_v [3];
   logic       tx_o   [3];
   logic       busy_o [3];
   logic       cmp_o  [3];
   logic       err_o  [3];

   int cpb [3] = '{4, 4, 2};
   int par [3] = '{0, 1, 0};
   int stp [3] = '{1, 2, 1};

   int cmp_cnt [3] = '{0, 0, 0};
   int err_cnt [3] = '{0, 0, 0};

   int checks = 0;
   int errors = 0;

   logic exp_q [$];

   assign ifa.data = data_v[0];
   assign ifa.send = send_v[0];
   assign ifb.data = data_v[1];
   assign ifb.send = send_v[1];
   assign ifc.data = data_v[2];
   assign ifc.send = send_v[2];

   assign tx_o[0] = ifa.tx;   assign busy_o[0] = ifa.busy_flag;
   assign cmp_o[0] = ifa.complate_flag; assign err_o[0] = ifa.error_flag;
   assign tx_o[1] = ifb.tx;   assign busy_o[1] = ifb.busy_flag;
   assign cmp_o[1] = ifb.complate_flag; assign err_o[1] = ifb.error_flag;
   assign tx_o[2] = ifc.tx;   assign busy_o[2] = ifc.busy_flag;
   assign cmp_o[2] = ifc.complate_flag; assign err_o[2] = ifc.error_flag;

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
      .sysclk(clk), .rst(rst), .bus(ifa));
   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
      .sysclk(clk), .rst(rst), .bus(ifb));
   uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(1)) dut_c (
      .sysclk(clk), .rst(rst), .bus(ifc));

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (cmp_o[k] === 1'b1) cmp_cnt[k]++;
         if (err_o[k] === 1'b1) err_cnt[k]++;
      end
   end

   function automatic void push_frame(int sel, logic [7:0] b);
      logic bits [$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (par[sel] != 0) bits.push_back(^b);
      for (int i = 0; i < stp[sel]; i++) bits.push_back(1'b1);
      foreach (bits[j])
         for (int c = 0; c < cpb[sel]; c++) exp_q.push_back(bits[j]);
   endfunction

   task automatic start_frame(input int sel, input logic [7:0] b);
      push_frame(sel, b);
      data_v[sel] = b;
      send_v[sel] = 1'b1;
      @(negedge clk);
      send_v[sel] = 1'b0;
      data_v[sel] = ~b;
   endtask

   task automatic check_frame(input int sel, input string name, input int err_at,
                              input bit chain, input logic [7:0] next_b);
      int   n;
      logic e;
      logic e_err;
      n = (9 + par[sel] + stp[sel]) * cpb[sel];
      for (int i = 0; i < n; i++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s underrun: cycle %0d, got queue empty, expected a bit", name, i);
         end else begin
            e = exp_q.pop_front();
            if (tx_o[sel] !== e) begin
               errors++;
               $display("FAIL %s tx cycle %0d: got %b expected %b", name, i, tx_o[sel], e);
            end
         end
         checks++;
         if (busy_o[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cycle %0d: got %b expected 1", name, i, busy_o[sel]);
         end
         checks++;
         if (cmp_o[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s complate cycle %0d: got %b expected 0", name, i, cmp_o[sel]);
         end
         e_err = (err_at >= 0 && i == err_at + 1);
         checks++;
         if (err_o[sel] !== e_err) begin
            errors++;
            $display("FAIL %s error_flag cycle %0d: got %b expected %b", name, i, err_o[sel], e_err);
         end
         if (i == err_at) begin
            send_v[sel] = 1'b1;
            data_v[sel] = 8'hFF;
         end else begin
            send_v[sel] = 1'b0;
         end
         @(negedge clk);
      end
      send_v[sel] = 1'b0;
      checks++;
      if (busy_o[sel] !== 1'b0 || cmp_o[sel] !== 1'b1 || tx_o[sel] !== 1'b1) begin
         errors++;
         $display("FAIL %s end: got busy=%b complate=%b tx=%b expected busy=0 complate=1 tx=1",
                  name, busy_o[sel], cmp_o[sel], tx_o[sel]);
      end
      if (chain) begin
         push_frame(sel, next_b);
         data_v[sel] = next_b;
         send_v[sel] = 1'b1;
         @(negedge clk);
         send_v[sel] = 1'b0;
         data_v[sel] = ~next_b;
      end else begin
         @(negedge clk);
         checks++;
         if (busy_o[sel] !== 1'b0 || cmp_o[sel] !== 1'b0 || tx_o[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: got busy=%b complate=%b tx=%b expected busy=0 complate=0 tx=1",
                     name, busy_o[sel], cmp_o[sel], tx_o[sel]);
         end
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d queued bits expected 0", name, exp_q.size());
         end
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (tx_o[k] !== 1'b1 || busy_o[k] !== 1'b0 || cmp_o[k] !== 1'b0 || err_o[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: got tx=%b busy=%b cmp=%b err=%b expected 1 0 0 0",
                     k, tx_o[k], busy_o[k], cmp_o[k], err_o[k]);
         end
      end
   endtask

   task automatic test_basic();
      start_frame(0, 8'hA5);
      check_frame(0, "basic_a5", -1, 1'b0, 8'h00);
      start_frame(0, 8'h81);
      check_frame(0, "basic_81", -1, 1'b0, 8'h00);
   endtask

   task automatic test_parity();
      start_frame(1, 8'hA5);
      check_frame(1, "parity_a5", -1, 1'b0, 8'h00);
      start_frame(1, 8'h01);
      check_frame(1, "parity_01", -1, 1'b0, 8'h00);
   endtask

   task automatic test_error();
      int e0;
      int c0;
      e0 = err_cnt[0];
      c0 = cmp_cnt[0];
      start_frame(0, 8'h3C);
      check_frame(0, "error_3c", 4, 1'b0, 8'h00);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (busy_o[0] !== 1'b0 || tx_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL error_no_second cycle %0d: got busy=%b tx=%b expected 0 1", i, busy_o[0], tx_o[0]);
         end
         @(negedge clk);
      end
      checks++;
      if (err_cnt[0] - e0 != 1) begin
         errors++;
         $display("FAIL error_count: got %0d pulses expected 1", err_cnt[0] - e0);
      end
      checks++;
      if (cmp_cnt[0] - c0 != 1) begin
         errors++;
         $display("FAIL error_cmp_count: got %0d pulses expected 1", cmp_cnt[0] - c0);
      end
   endtask

   task automatic test_back_to_back();
      start_frame(0, 8'hC3);
      check_frame(0, "b2b_first", -1, 1'b1, 8'h55);
      check_frame(0, "b2b_second", -1, 1'b0, 8'h00);
   endtask

   task automatic test_min_cpb();
      start_frame(2, 8'h00);
      check_frame(2, "cpb2_00", -1, 1'b0, 8'h00);
      start_frame(2, 8'hFF);
      check_frame(2, "cpb2_ff", -1, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid_frame();
      int   c0;
      logic e;
      c0 = cmp_cnt[0];
      start_frame(0, 8'hA5);
      for (int i = 0; i < 10; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (tx_o[0] !== e) begin
            errors++;
            $display("FAIL rst_pre tx cycle %0d: got %b expected %b", i, tx_o[0], e);
         end
         @(negedge clk);
      end
      exp_q.delete();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || cmp_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: got tx=%b busy=%b cmp=%b expected 1 0 0", tx_o[0], busy_o[0], cmp_o[0]);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold cycle %0d: got tx=%b busy=%b expected 1 0", i, tx_o[0], busy_o[0]);
         end
      end
      rst = 1'b0;
      start_frame(0, 8'h5A);
      check_frame(0, "rst_restart", -1, 1'b0, 8'h00);
      checks++;
      if (cmp_cnt[0] - c0 != 1) begin
         errors++;
         $display("FAIL rst_cmp_count: got %0d pulses expected 1", cmp_cnt[0] - c0);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_v[k] = 8'h00;
         send_v[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_basic();
      test_parity();
      test_error();
      test_back_to_back();
      test_min_cpb();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SYSCLK cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0, 1 = insert even-parity bit between data and stop.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 SYSCLK  in  1  system clock; all logic on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 DATA  in  8  byte to transmit; sampled only when a frame is accepted.
REQ-007 SEND  in  1  single-cycle transmit request strobe.
REQ-008 TX  out  1  serial line; idle high.
REQ-009 BUSY_FLAG  out  1  high while a frame is in progress.
REQ-010 COMPLATE_FLAG  out  1  one-cycle pulse when a frame finishes.
REQ-011 ERROR_FLAG  out  1  one-cycle pulse when SEND is rejected.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; one-hot or binary encoding is free.
REQ-013 IDLE: SEND=1 with BUSY_FLAG=0 accepts a frame: DATA latched into a shift register, state goes to START, bit counter = 0, baud counter = 0.
REQ-014 TX, BUSY_FLAG, COMPLATE_FLAG and ERROR_FLAG are registered outputs; TX goes low and BUSY_FLAG goes high on the edge that accepts SEND (1-cycle latency).
REQ-015 Each bit lasts exactly CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1 and wraps, and a bit ends on the wrap.
REQ-016 START: TX=0 for one bit time, then go to DATA.
REQ-017 DATA: 8 bits, LSB first; TX = shift register bit 0, shifted right at each bit end; after bit 7 go to PARITY if PARITY_EN, else STOP.
REQ-018 PARITY: TX = XOR of the latched 8 data bits (even parity) for one bit time, then go to STOP.
REQ-019 STOP: TX=1 for STOP_BITS bit times, then go to IDLE.
REQ-020 On the STOP-to-IDLE edge: BUSY_FLAG goes low and COMPLATE_FLAG pulses high for exactly one cycle.
REQ-021 Frame length is (1+8+PARITY_EN+STOP_BITS) x CLKS_PER_BIT cycles from the first TX-low cycle to BUSY_FLAG falling.
REQ-022 A SEND arriving in the same cycle that COMPLATE_FLAG is high is accepted (BUSY_FLAG=0); this gives back-to-back frames with no idle gap.
REQ-023 SEND=1 while BUSY_FLAG=1: request ignored; DATA not sampled; frame in progress undisturbed; ERROR_FLAG pulses high in the next cycle, once for each such cycle.
REQ-024 DATA changes while BUSY_FLAG=1 have no effect on the frame in progress.
REQ-025 Counters are sized to $clog2(CLKS_PER_BIT) bits (baud counter) and 3 bits (bit index); no overflow paths beyond the defined wrap.

Reset
REQ-026 RST=1 forces, asynchronously: TX=1, BUSY_FLAG=0, COMPLATE_FLAG=0, ERROR_FLAG=0, state=IDLE, all counters and the shift register 0.
REQ-027 RST during a frame aborts it; no COMPLATE_FLAG is issued; TX returns high immediately.
REQ-028 The first SEND is accepted on the first rising edge after RST deasserts.

Structure
REQ-029 Shared package uart_pkg holds the FSM state encoding, the frame-format constants, and a function computing CLKS_PER_BIT from clock frequency and baud; uart_rx uses the same package.
REQ-030 One sub-module, uart_baud_gen, provides the baud counter and a bit-end tick; it is cleared by the FSM on frame accept.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-031 Reset: assert RST mid-frame (cycle 10 of a frame) -> TX=1, BUSY_FLAG=0 in the same cycle; no COMPLATE_FLAG pulse.
REQ-032 Send 0xA5, PARITY_EN=0, STOP_BITS=1 -> TX sequence of 4-cycle bits 0,1,0,1,0,0,1,0,1,1; BUSY_FLAG high for 40 cycles; COMPLATE_FLAG 1 cycle.
REQ-033 Send 0xA5 with PARITY_EN=1 and STOP_BITS=2 -> parity bit 0, 48-cycle frame; send 0x01 -> parity bit 1.
REQ-034 SEND 0x3C, then SEND 0xFF at cycle 5 -> ERROR_FLAG 1-cycle pulse; frame carries 0x3C only; no second frame.
REQ-035 SEND 0x55 on the COMPLATE_FLAG cycle of a previous frame -> next start bit immediately follows the stop bit with no idle cycles.
REQ-036 CLKS_PER_BIT=2 boundary: send 0x00 -> 20-cycle frame, every bit exactly 2 cycles.
